// File: rtl/slg46620_cnt0_pkg.sv
// Shared types for the SLG46620 CNT0 counter/delay macrocell.
package slg46620_cnt0_pkg;

  localparam int unsigned DEFAULT_BIT_WIDTH = 14;

  typedef enum logic [1:0] {
    Both_Edge_Reset    = 2'd0,
    Falling_Edge_Reset = 2'd1,
    Rising_Edge_Reset  = 2'd2,
    High_level_Reset   = 2'd3
  } edge_sel_t;

  typedef enum logic [1:0] {
    CNT      = 2'd0,
    DLY      = 2'd1,
    ONE_SHOT = 2'd2,
    FSM      = 2'd3
  } func_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cnt0_state_t;

  // DLY and ONE_SHOT take their event from i_in; CNT and FSM from i_resetin.
  function automatic logic is_trigger_mode(input func_sel_t f);
    return (f == DLY) || (f == ONE_SHOT);
  endfunction

endpackage

// File: rtl/cnt0_edge_qual.sv
// Input sample flop plus rise/fall detection and event qualification for CNT0.
module cnt0_edge_qual
  import slg46620_cnt0_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_sig,
  input  logic       i_trig_mode,
  input  logic [1:0] i_edge_select,
  output logic       o_event_c,
  output logic       o_abort_c
);

  logic s;
  logic rise;
  logic fall;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) s <= 1'b0;
    else         s <= i_sig;
  end

  assign rise = i_sig & ~s;
  assign fall = ~i_sig & s;

  // Abort flags the opposite-polarity edge when only one polarity qualifies.
  always_comb begin
    o_event_c = 1'b0;
    o_abort_c = 1'b0;
    case (edge_sel_t'(i_edge_select))
      Both_Edge_Reset:    o_event_c = rise | fall;
      Falling_Edge_Reset: begin
        o_event_c = fall;
        o_abort_c = rise;
      end
      Rising_Edge_Reset:  begin
        o_event_c = rise;
        o_abort_c = fall;
      end
      High_level_Reset:   o_event_c = i_trig_mode ? (rise | fall) : i_sig;
      default:            ;
    endcase
  end

endmodule

// File: rtl/cnt0_sequencer.sv
// CNT0 mode sequencer: owns the counter register and runs CNT, DLY, ONE_SHOT or FSM.
module cnt0_sequencer
  import slg46620_cnt0_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [1:0]           i_function_select,
  input  logic [1:0]           i_edge_select,
  input  logic [BIT_WIDTH-1:0] i_data,
  input  logic                 i_in,
  input  logic                 i_resetin,
  input  logic                 i_up,
  output logic [BIT_WIDTH-1:0] o_counter,
  output logic                 o_out,
  output logic                 o_busy
);

  func_sel_t            func_in;
  func_sel_t            func_q;
  func_sel_t            func_d;
  cnt0_state_t          state;
  cnt0_state_t          state_d;
  logic [BIT_WIDTH-1:0] cnt_d;
  logic [BIT_WIDTH-1:0] cnt_dec;
  logic [BIT_WIDTH-1:0] fsm_next;
  logic [BIT_WIDTH-1:0] fsm_term;
  logic                 cnt_zero;
  logic                 out_d;
  logic                 busy_d;
  logic                 target;
  logic                 target_d;
  logic                 trig_mode;
  logic                 active_in;
  logic                 func_chg;
  logic                 evt_c;
  logic                 abort_c;

  assign func_in   = func_sel_t'(i_function_select);
  assign trig_mode = is_trigger_mode(func_in);
  assign active_in = trig_mode ? i_in : i_resetin;
  assign func_chg  = (func_in != func_q);
  assign cnt_zero  = (o_counter == '0);
  assign cnt_dec   = o_counter - BIT_WIDTH'(1);

  cnt0_edge_qual u_edge_qual (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_sig         (active_in),
    .i_trig_mode   (trig_mode),
    .i_edge_select (i_edge_select),
    .o_event_c     (evt_c),
    .o_abort_c     (abort_c)
  );

  // FSM-mode next count: reset event, hold, or saturating up/down step.
  always_comb begin
    fsm_term = i_up ? i_data : '0;
    fsm_next = o_counter;
    if (evt_c) begin
      fsm_next = '0;
    end else if (!i_in) begin
      if (i_up) begin
        if (o_counter < i_data) fsm_next = o_counter + BIT_WIDTH'(1);
      end else if (!cnt_zero) begin
        fsm_next = cnt_dec;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      func_q    <= CNT;
      o_counter <= '0;
      o_out     <= 1'b0;
      o_busy    <= 1'b0;
      target    <= 1'b0;
    end else begin
      state     <= state_d;
      func_q    <= func_d;
      o_counter <= cnt_d;
      o_out     <= out_d;
      o_busy    <= busy_d;
      target    <= target_d;
    end
  end

  // Priority: function change, then event, then expiry, then count.
  always_comb begin
    state_d  = state;
    func_d   = func_q;
    cnt_d    = o_counter;
    out_d    = o_out;
    target_d = target;

    if (func_chg) begin
      state_d = IDLE;
      func_d  = func_in;
      out_d   = 1'b0;
      cnt_d   = (func_in == FSM) ? '0 : i_data;
    end else begin
      case (func_q)
        CNT: begin
          if ((state == IDLE) || evt_c) begin
            state_d = RUN;
            cnt_d   = i_data;
            out_d   = 1'b0;
          end else if (cnt_zero) begin
            cnt_d = i_data;
            out_d = 1'b1;
          end else begin
            cnt_d = cnt_dec;
            out_d = 1'b0;
          end
        end
        DLY: begin
          if (evt_c) begin
            state_d  = RUN;
            cnt_d    = i_data;
            target_d = i_in;
          end else if (state == RUN) begin
            if (abort_c) begin
              state_d = IDLE;
              out_d   = i_in;
            end else if (cnt_zero) begin
              state_d = IDLE;
              out_d   = target;
            end else begin
              cnt_d = cnt_dec;
            end
          end
        end
        ONE_SHOT: begin
          if (state == IDLE) begin
            if (evt_c) begin
              state_d = RUN;
              cnt_d   = i_data;
              out_d   = 1'b1;
            end
          end else if (cnt_zero) begin
            state_d = IDLE;
            out_d   = 1'b0;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        FSM: begin
          if (state == IDLE) begin
            state_d = RUN;
            cnt_d   = '0;
            out_d   = 1'b0;
          end else begin
            cnt_d = fsm_next;
            out_d = (fsm_next == fsm_term);
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == RUN) && is_trigger_mode(func_d);
  end

endmodule

// File: tb/tb_cnt0_sequencer.sv
// Self-checking bench for cnt0_sequencer: directed scenarios plus randomized run against a timing model.
module tb_cnt0_sequencer;
  import slg46620_cnt0_pkg::*;

  localparam int unsigned W = 14;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   fsel = 2'd0;
  logic [1:0]   esel = 2'd2;
  logic [W-1:0] data = '0;
  logic         in_sig = 1'b0;
  logic         resetin = 1'b0;
  logic         up = 1'b1;
  logic [W-1:0] o_counter;
  logic         o_out;
  logic         o_busy;

  int errors = 0;
  int checks = 0;

  cnt0_sequencer #(.BIT_WIDTH(W)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_function_select (fsel),
    .i_edge_select     (esel),
    .i_data            (data),
    .i_in              (in_sig),
    .i_resetin         (resetin),
    .i_up              (up),
    .o_counter         (o_counter),
    .o_out             (o_out),
    .o_busy            (o_busy)
  );

  always #5 clk = ~clk;

  // Timing model: counts are tracked as (load value, load time) and deadlines, not as a register.
  int unsigned cyc = 0;
  int unsigned m_load_t, m_load_v, m_hold, m_deadline;
  bit          m_counting, m_armed, m_out, m_busy, m_tgt, m_s;
  logic [1:0]  m_fn;

  function automatic int unsigned exp_count();
    if (!m_counting) return m_hold;
    if (cyc - m_load_t > m_load_v) return 0;
    return m_load_v - (cyc - m_load_t);
  endfunction

  task automatic model_reset();
    m_fn = CNT; m_armed = 0; m_counting = 0; m_hold = 0;
    m_out = 0; m_busy = 0; m_s = 0; m_tgt = 0;
  endtask

  task automatic m_start(input int unsigned v);
    m_counting = 1; m_load_v = v; m_load_t = cyc;
  endtask

  task automatic m_freeze(input int unsigned v);
    m_counting = 0; m_hold = v;
  endtask

  task automatic model_edge();
    bit trig, act, rise, fall, ev, other;
    int unsigned cur, nxt, d;
    d    = int'(data);
    trig = (fsel == DLY) || (fsel == ONE_SHOT);
    act  = trig ? in_sig : resetin;
    rise = act && !m_s;
    fall = !act && m_s;
    ev = 0; other = 0;
    case (esel)
      2'd0: ev = rise | fall;
      2'd1: begin ev = fall; other = rise; end
      2'd2: begin ev = rise; other = fall; end
      default: ev = trig ? (rise | fall) : act;
    endcase
    m_s = act;
    cur = exp_count();
    cyc++;
    if (fsel != m_fn) begin
      m_fn = fsel; m_armed = 0; m_out = 0; m_busy = 0;
      m_freeze((fsel == FSM) ? 0 : d);
      return;
    end
    case (m_fn)
      CNT: begin
        if (!m_armed || ev) begin m_armed = 1; m_start(d); m_out = 0; end
        else if (cur == 0) begin m_start(d); m_out = 1; end
        else m_out = 0;
      end
      DLY: begin
        if (ev) begin
          m_start(d); m_tgt = in_sig; m_busy = 1; m_deadline = cyc + d + 1;
        end else if (m_busy) begin
          if (other) begin m_freeze(cur); m_out = in_sig; m_busy = 0; end
          else if (cyc == m_deadline) begin m_freeze(0); m_out = m_tgt; m_busy = 0; end
        end
      end
      ONE_SHOT: begin
        if (!m_busy) begin
          if (ev) begin m_start(d); m_out = 1; m_busy = 1; m_deadline = cyc + d + 1; end
        end else if (cyc == m_deadline) begin
          m_freeze(0); m_out = 0; m_busy = 0;
        end
      end
      default: begin
        if (!m_armed) begin m_armed = 1; m_freeze(0); m_out = 0; end
        else begin
          if (ev) nxt = 0;
          else if (in_sig) nxt = cur;
          else if (up) nxt = (cur < d) ? cur + 1 : cur;
          else nxt = (cur > 0) ? cur - 1 : 0;
          m_freeze(nxt);
          m_out = (nxt == (up ? d : 0));
        end
      end
    endcase
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] fn, input logic [1:0] es, input int unsigned n);
    fsel = fn; esel = es; data = W'(n); in_sig = 0; resetin = 0; up = 1;
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    fsel = CNT; esel = Rising_Edge_Reset; data = W'(3);
    #1 rst = 1;
    model_reset();
    #1;
    checks++; if (o_counter !== '0) begin errors++; $display("FAIL reset_counter: got %0d want 0", o_counter); end
    checks++; if (o_out !== 1'b0)   begin errors++; $display("FAIL reset_out: got %b want 0", o_out); end
    checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    @(posedge clk); #1;
    checks++; if (o_counter !== '0) begin errors++; $display("FAIL reset_held_counter: got %0d want 0", o_counter); end
    rst = 0;
    tick();
    checks++; if (o_counter !== W'(3)) begin errors++; $display("FAIL release_load: got %0d want 3", o_counter); end
    checks++; if (o_out !== 1'b0)     begin errors++; $display("FAIL release_out: got %b want 0", o_out); end
  endtask

  task automatic test_cnt();
    do_reset(CNT, Rising_Edge_Reset, 3);
    for (int k = 1; k <= 14; k++) begin
      tick();
      checks++;
      if (o_out !== ((k > 1) && (k % 4 == 1))) begin
        errors++; $display("FAIL cnt_pulse k=%0d: got %b want %b", k, o_out, (k > 1) && (k % 4 == 1));
      end
      checks++;
      if (o_counter !== W'(3 - ((k - 1) % 4))) begin
        errors++; $display("FAIL cnt_value k=%0d: got %0d want %0d", k, o_counter, 3 - ((k - 1) % 4));
      end
    end
    resetin = 1;
    tick();
    checks++; if (o_counter !== W'(3)) begin errors++; $display("FAIL cnt_reset_reload: got %0d want 3", o_counter); end
    resetin = 0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      checks++;
      if (o_out !== (j == 4)) begin errors++; $display("FAIL cnt_after_reset j=%0d: got %b want %b", j, o_out, j == 4); end
    end
  endtask

  task automatic test_dly_both();
    do_reset(DLY, Both_Edge_Reset, 5);
    tick(); tick(); tick();
    in_sig = 1;
    tick();
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL dly_start_busy: got %b want 1", o_busy); end
    for (int j = 1; j <= 6; j++) begin
      tick();
      checks++;
      if (o_out !== (j == 6)) begin errors++; $display("FAIL dly_out j=%0d: got %b want %b", j, o_out, j == 6); end
      checks++;
      if (o_busy !== (j < 6)) begin errors++; $display("FAIL dly_busy j=%0d: got %b want %b", j, o_busy, j < 6); end
    end
    for (int j = 0; j < 10; j++) begin
      in_sig = !((j == 0) || (j == 1));
      tick();
      if (j == 2) begin
        checks++;
        if (o_counter !== W'(5)) begin errors++; $display("FAIL dly_glitch_restart: got %0d want 5", o_counter); end
      end
      checks++;
      if (o_out !== 1'b1) begin errors++; $display("FAIL dly_glitch_out j=%0d: got %b want 1", j, o_out); end
    end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL dly_glitch_done: got %b want 0", o_busy); end
  endtask

  task automatic test_dly_abort();
    do_reset(DLY, Rising_Edge_Reset, 4);
    tick(); tick();
    in_sig = 1;
    for (int j = 0; j < 6; j++) tick();
    checks++; if (o_out !== 1'b1) begin errors++; $display("FAIL abort_setup: got %b want 1", o_out); end
    in_sig = 0;
    tick(); tick();
    checks++; if (o_out !== 1'b1) begin errors++; $display("FAIL abort_idle_fall: got %b want 1", o_out); end
    in_sig = 1;
    tick(); tick();
    in_sig = 0;
    tick();
    checks++; if (o_out !== 1'b0)     begin errors++; $display("FAIL abort_out: got %b want 0", o_out); end
    checks++; if (o_busy !== 1'b0)    begin errors++; $display("FAIL abort_busy: got %b want 0", o_busy); end
    checks++; if (o_counter !== W'(3)) begin errors++; $display("FAIL abort_counter: got %0d want 3", o_counter); end
    for (int j = 0; j < 6; j++) begin
      tick();
      checks++;
      if (o_out !== 1'b0) begin errors++; $display("FAIL abort_stay j=%0d: got %b want 0", j, o_out); end
    end
  endtask

  task automatic test_one_shot();
    do_reset(ONE_SHOT, Rising_Edge_Reset, 2);
    tick(); tick();
    for (int j = 0; j <= 4; j++) begin
      in_sig = (j != 1);
      tick();
      checks++;
      if (o_out !== (j <= 2)) begin errors++; $display("FAIL oneshot_out j=%0d: got %b want %b", j, o_out, j <= 2); end
      checks++;
      if (o_counter !== W'((j < 2) ? 2 - j : 0)) begin
        errors++; $display("FAIL oneshot_count j=%0d: got %0d want %0d", j, o_counter, (j < 2) ? 2 - j : 0);
      end
    end
  endtask

  task automatic test_fsm();
    int exp_c;
    do_reset(FSM, Rising_Edge_Reset, 7);
    tick(); tick();
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_c = (k < 7) ? k : 7;
      checks++;
      if (o_counter !== W'(exp_c)) begin errors++; $display("FAIL fsm_up k=%0d: got %0d want %0d", k, o_counter, exp_c); end
      checks++;
      if (o_out !== (exp_c == 7)) begin errors++; $display("FAIL fsm_up_out k=%0d: got %b want %b", k, o_out, exp_c == 7); end
    end
    in_sig = 1; up = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (o_counter !== W'(7)) begin errors++; $display("FAIL fsm_hold k=%0d: got %0d want 7", k, o_counter); end
    end
    in_sig = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_c = (k < 7) ? 7 - k : 0;
      checks++;
      if (o_counter !== W'(exp_c)) begin errors++; $display("FAIL fsm_down k=%0d: got %0d want %0d", k, o_counter, exp_c); end
      checks++;
      if (o_out !== (exp_c == 0)) begin errors++; $display("FAIL fsm_down_out k=%0d: got %b want %b", k, o_out, exp_c == 0); end
    end
  endtask

  task automatic test_async_and_change();
    do_reset(ONE_SHOT, Rising_Edge_Reset, 10);
    tick(); tick();
    in_sig = 1;
    tick(); tick(); tick();
    checks++; if (o_out !== 1'b1) begin errors++; $display("FAIL async_setup: got %b want 1", o_out); end
    #2 rst = 1;
    model_reset();
    #1;
    checks++; if (o_out !== 1'b0)   begin errors++; $display("FAIL async_out: got %b want 0", o_out); end
    checks++; if (o_counter !== '0) begin errors++; $display("FAIL async_counter: got %0d want 0", o_counter); end
    checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL async_busy: got %b want 0", o_busy); end
    @(posedge clk); #1;
    fsel = CNT; data = '0; in_sig = 0; rst = 0;
    tick(); tick(); tick();
    checks++; if (o_out !== 1'b1) begin errors++; $display("FAIL cnt_n0_out: got %b want 1", o_out); end
    fsel = DLY; data = W'(9);
    tick();
    checks++; if (o_out !== 1'b0)     begin errors++; $display("FAIL change_out: got %b want 0", o_out); end
    checks++; if (o_busy !== 1'b0)    begin errors++; $display("FAIL change_busy: got %b want 0", o_busy); end
    checks++; if (o_counter !== W'(9)) begin errors++; $display("FAIL change_counter: got %0d want 9", o_counter); end
  endtask

  task automatic test_random();
    do_reset(CNT, Rising_Edge_Reset, 4);
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 39) == 0) fsel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) esel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)  data = W'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0)  in_sig = ~in_sig;
      if ($urandom_range(0, 5) == 0)  resetin = ~resetin;
      if ($urandom_range(0, 9) == 0)  up = ~up;
      tick();
      checks++;
      if (o_counter !== W'(exp_count())) begin
        errors++; $display("FAIL rand_counter cyc=%0d: got %0d want %0d", cyc, o_counter, exp_count());
      end
      checks++;
      if (o_out !== m_out) begin errors++; $display("FAIL rand_out cyc=%0d: got %b want %b", cyc, o_out, m_out); end
      checks++;
      if (o_busy !== m_busy) begin errors++; $display("FAIL rand_busy cyc=%0d: got %b want %b", cyc, o_busy, m_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_cnt();
    test_dly_both();
    test_dly_abort();
    test_one_shot();
    test_fsm();
    test_async_and_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
